hpi_xfer_seq: RTL
=================

# hpi_xfer_seq

Hardware transaction sequencer for the CY7C67200 host-port interface (HPI). It sits directly upstream of the registered HPI pin interface and drives its `from_sw_*` inputs. It turns one-word memory or register requests into correctly timed address-phase and data-phase strobe sequences, so software no longer bit-bangs chip-select, read and write. Read data returning through the pin interface is captured and handed back with a one-cycle response pulse.

## Interface
Parameters:
- `SETUP_CYCLES`, 1: cycles with CS low, address/data stable and strobe high before the strobe. Must be 1..255.
- `STROBE_CYCLES`, 4: cycles with RD or WR held low. Must be 1..255.
- `RECOVERY_CYCLES`, 2: cycles with CS, RD and WR high after the strobe. Must be 2..255.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  reset, asynchronous, active-high. Clock is `Clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE. A request is accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_direct`  in  1  1 = single access to HPI register `req_addr[1:0]`. 0 = chip-memory access at `req_addr`.
- `req_addr`  in  16  chip memory address, or register index when `req_direct` is set.
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, for reads and writes.
- `rsp_rdata`  out  16  last read data. Held until the next read completes; writes leave it unchanged.
- `busy`  out  1  equal to `~req_ready`.
- `hpi_address`  out  2  drives the interface's `from_sw_address`.
- `hpi_data_out`  out  16  drives `from_sw_data_out`.
- `hpi_data_in`  in  16  from `from_sw_data_in`.
- `hpi_r`, `hpi_w`, `hpi_cs`  out  1 each  active-low strobes that drive `from_sw_r`, `from_sw_w` and `from_sw_cs`.
- `hpi_int`  in  1  OTG_INT level, sampled only when `HPI_IRQ_LATCH_EN` is defined.
- `irq_ack`  in  1  clears `irq_pending`.
- `irq_pending`  out  1  latched interrupt.

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_RECOV, D_SETUP, D_STROBE, D_RECOV, DONE.
- On acceptance, all request fields are registered.
  - Memory access goes to A_SETUP.
  - Direct access goes to D_SETUP.
- Address phase (A_*):
  - `hpi_address`=2'b10 (HPI_ADDR).
  - `hpi_data_out`=latched addr.
  - The strobe is always a write.
- Data phase (D_*):
  - `hpi_address`=2'b00 (HPI_DATA) for memory access, latched `addr[1:0]` for direct access.
  - `hpi_data_out`=latched wdata.
  - `hpi_w` is low in D_STROBE for writes; `hpi_r` is low in D_STROBE for reads.
- Signal levels by state:
  - SETUP: `hpi_cs`=0, both strobes 1.
  - STROBE: `hpi_cs`=0, one strobe 0.
  - RECOV: `hpi_cs`, `hpi_r`, `hpi_w` all 1.
  - IDLE/DONE: all strobes 1, `hpi_address`=0, `hpi_data_out`=0.
- Each timed state lasts exactly its parameter count, using an 8-bit down-counter loaded on entry.
- A_RECOV goes to D_SETUP. D_RECOV goes to DONE. DONE lasts 1 cycle, pulses `rsp_valid`, then returns to IDLE.
- Reads: `hpi_data_in` is captured into `rsp_rdata` at the clock edge ending the second D_RECOV cycle.
- Only one transaction is outstanding at a time. `req_valid` is ignored while busy.
- Reset values:
  - State IDLE, counter 0.
  - `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0.
  - `hpi_cs`=`hpi_r`=`hpi_w`=1, `hpi_address`=0, `hpi_data_out`=0.
  - `irq_pending`=0.
- Reset mid-transaction: the machine returns to IDLE immediately and the strobes deassert asynchronously. No `rsp_valid` is issued. The request is lost.

## Timing
- All outputs are registered.
- Downstream pin interface latency:
  - Pins lag this block's outputs by 1 cycle.
  - `hpi_data_in` lags the pins by 1 cycle.
  - So pin data from the last pin-strobe cycle appears on `hpi_data_in` in the second cycle after `hpi_r` rises. This is why `RECOVERY_CYCLES` must be at least 2.
- Latency from the acceptance edge to the cycle `rsp_valid` is high:
  - Memory access: 2·(S+T+R)+1. Defaults give 15 cycles.
  - Direct access: S+T+R+1. Defaults give 8 cycles.
- `req_ready` returns high in the cycle after DONE. A back-to-back request can be accepted on that edge.
- `rsp_valid` and `req_ready` are never high in the same cycle.

## Configuration
- Macro: `HPI_IRQ_LATCH_EN`.
- Defined:
  - `hpi_int` is synchronised through 2 flops.
  - A rising edge sets `irq_pending`.
  - `irq_ack` clears it.
  - If the set and the ack occur in the same cycle, the set wins.
- Undefined:
  - `irq_pending` is tied to 0.
  - `hpi_int` and `irq_ack` are ignored.
  - No synchroniser flops exist.
- The port list is identical in both builds.

## Test plan
- Memory write, addr 16'h1000, wdata 16'hBEEF, defaults -> address phase shows `hpi_address`=2, `hpi_data_out`=16'h1000, `hpi_w` low 4 cycles. Data phase shows `hpi_address`=0, data 16'hBEEF, `hpi_w` low 4 cycles. `rsp_valid` in cycle 15.
- Memory read, addr 16'h0140; model returns 16'h1234 through a 2-cycle-lag pin model -> `hpi_r` low 4 cycles. `rsp_rdata`=16'h1234 with `rsp_valid` in cycle 15.
- Direct read of register 3 (status), model 16'h0001 -> no address phase, `hpi_address`=3. `rsp_valid` in cycle 8 with `rsp_rdata`=16'h0001.
- `req_valid` held high continuously with two queued requests -> second is accepted exactly 1 cycle after the first `rsp_valid`. No request is accepted while busy.
- Reset asserted during A_STROBE -> `hpi_w` and `hpi_cs` go to 1 without a clock edge, state is IDLE, no `rsp_valid`. A following request completes normally.
- With `HPI_IRQ_LATCH_EN`: `hpi_int` 0→1 -> `irq_pending`=1 after 3 edges. `irq_ack` clears it. Edge coincident with ack leaves it set. Without the macro, `irq_pending` stays 0.

Source files
------------

// File: rtl/hpi_xfer_seq.sv
// ----------------------------------------------------------------------------
// hpi_xfer_seq
//
// Purpose:
//   Transaction sequencer for the CY7C67200 host-port interface. It accepts
//   one-word memory or register requests and produces the timed chip-select,
//   read and write strobe sequences for the registered HPI pin interface.
//   A memory access is an address phase (write of the address to HPI_ADDR)
//   followed by a data phase on HPI_DATA. A direct access is only a data
//   phase on register req_addr[1:0]. Read data is captured and returned with
//   a one-cycle rsp_valid pulse.
//
// Optional feature:
//   HPI_IRQ_LATCH_EN - when defined, hpi_int is synchronised through two
//   flops and a rising edge sets irq_pending (cleared by irq_ack, set wins).
//   When undefined, irq_pending is tied low and hpi_int/irq_ack are ignored.
//
// Parameters:
//   SETUP_CYCLES    (1..255) cycles with CS low before the strobe
//   STROBE_CYCLES   (1..255) cycles with RD or WR low
//   RECOVERY_CYCLES (2..255) cycles with CS/RD/WR high after the strobe
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_write           1 = write, 0 = read
//   req_direct          1 = direct register access at req_addr[1:0]
//   req_addr, req_wdata request address and write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           last read data, held until the next read completes
//   busy                ~req_ready
//   hpi_address         to from_sw_address
//   hpi_data_out        to from_sw_data_out
//   hpi_data_in         from from_sw_data_in
//   hpi_r, hpi_w, hpi_cs active-low strobes to from_sw_r/w/cs
//   hpi_int, irq_ack    interrupt input and acknowledge
//   irq_pending         latched interrupt
//
// Handshake: a request transfers on the rising Clk edge where req_valid and
// req_ready are both high; all request fields are sampled on that edge and
// the requester may change them afterwards. req_valid is ignored while busy.
// ----------------------------------------------------------------------------
module hpi_xfer_seq #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 4,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_direct,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_cs,
    input  logic        hpi_int,
    input  logic        irq_ack,
    output logic        irq_pending
);

    localparam logic [1:0] HPI_DATA = 2'b00;
    localparam logic [1:0] HPI_ADDR = 2'b10;

    // Down-counter reload values: a state lasting N cycles counts N-1..0.
    localparam logic [7:0] SETUP_LD    = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD   = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] RECOVERY_LD = 8'(RECOVERY_CYCLES - 1);
    // Counter value during the second D_RECOV cycle. Read data from the last
    // pin-strobe cycle arrives on hpi_data_in two cycles after hpi_r rises.
    localparam logic [7:0] CAPTURE_CNT = 8'(RECOVERY_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_RECOV  = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_RECOV  = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        write_q, direct_q;
    logic [15:0] addr_q, wdata_q;

    logic        accept;
    logic        eff_write, eff_direct;
    logic [15:0] eff_addr, eff_wdata;

    logic        cs_nxt, r_nxt, w_nxt;
    logic [1:0]  address_nxt;
    logic [15:0] data_out_nxt;

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign busy   = ~req_ready;

    // On the acceptance edge the latched fields are not yet loaded, so the
    // first-cycle outputs are decoded from the live request.
    assign eff_write  = accept ? req_write  : write_q;
    assign eff_direct = accept ? req_direct : direct_q;
    assign eff_addr   = accept ? req_addr   : addr_q;
    assign eff_wdata  = accept ? req_wdata  : wdata_q;

    // Next state and counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_direct ? D_SETUP : A_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            A_SETUP, D_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = (state == A_SETUP) ? A_STROBE : D_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            A_STROBE, D_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt = (state == A_STROBE) ? A_RECOV : D_RECOV;
                    cnt_nxt   = RECOVERY_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            A_RECOV: begin
                if (cnt == 8'd0) begin
                    state_nxt = D_SETUP;
                    cnt_nxt   = SETUP_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            D_RECOV: begin
                if (cnt == 8'd0) begin
                    state_nxt = DONE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Pin-side levels for the state being entered; registered below so all
    // outputs come straight from flops.
    always_comb begin
        cs_nxt       = 1'b1;
        r_nxt        = 1'b1;
        w_nxt        = 1'b1;
        address_nxt  = 2'b00;
        data_out_nxt = 16'h0000;
        case (state_nxt)
            A_SETUP, A_STROBE, A_RECOV: begin
                address_nxt  = HPI_ADDR;
                data_out_nxt = eff_addr;
                cs_nxt       = (state_nxt == A_RECOV);
                w_nxt        = (state_nxt != A_STROBE);
            end
            D_SETUP, D_STROBE, D_RECOV: begin
                address_nxt  = eff_direct ? eff_addr[1:0] : HPI_DATA;
                data_out_nxt = eff_wdata;
                cs_nxt       = (state_nxt == D_RECOV);
                if (state_nxt == D_STROBE) begin
                    w_nxt = ~eff_write;
                    r_nxt = eff_write;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            write_q      <= 1'b0;
            direct_q     <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            hpi_cs       <= 1'b1;
            hpi_r        <= 1'b1;
            hpi_w        <= 1'b1;
            hpi_address  <= 2'b00;
            hpi_data_out <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                write_q  <= req_write;
                direct_q <= req_direct;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            req_ready    <= (state_nxt == IDLE);
            rsp_valid    <= (state_nxt == DONE);
            hpi_cs       <= cs_nxt;
            hpi_r        <= r_nxt;
            hpi_w        <= w_nxt;
            hpi_address  <= address_nxt;
            hpi_data_out <= data_out_nxt;
            if ((state == D_RECOV) && (cnt == CAPTURE_CNT) && !write_q)
                rsp_rdata <= hpi_data_in;
        end
    end

`ifdef HPI_IRQ_LATCH_EN
    logic int_s1, int_s2, int_s3;
    logic irq_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_s3 <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            int_s1 <= hpi_int;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
            // A new edge takes priority over an acknowledge in the same cycle.
            if (int_s2 && !int_s3)
                irq_q <= 1'b1;
            else if (irq_ack)
                irq_q <= 1'b0;
        end
    end

    assign irq_pending = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = hpi_int ^ irq_ack;
    assign irq_pending       = 1'b0;
`endif

endmodule
